// File: rtl/alu_stream_engine.sv
// Handshaked byte-stream front end for the 8-bit ALU.
// Takes A then B+opcode beats and queues {op,F} results in a small FIFO.
module alu_stream_engine #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       out_op,
    output logic [CNT_W-1:0] res_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        WAIT_A,
        WAIT_B
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       a_q, a_d;
    logic [11:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic [CNT_W-1:0] res_q;

    logic             hs, push, pop;
    logic [7:0]       f;
    logic [2:0]       sh;
    logic [15:0]      rol_w, ror_w, mul_w;

    assign in_ready  = rst_n & ~clr & (cnt_q < CW'(DEPTH));
    assign hs        = in_valid & in_ready;
    assign push      = hs & (state_q == WAIT_B);
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready & ~clr;
    assign out_data  = out_valid ? mem_q[rd_q][7:0] : 8'h00;
    assign out_op    = out_valid ? mem_q[rd_q][11:8] : 4'h0;
    assign res_cnt   = res_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        if (clr) begin
            state_d = WAIT_A;
        end else if (hs) begin
            unique case (state_q)
                WAIT_A: begin
                    a_d     = in_data;
                    state_d = WAIT_B;
                end
                WAIT_B: state_d = WAIT_A;
                default: state_d = WAIT_A;
            endcase
        end
    end

    // Rotates come from the upper/lower half of a doubled operand.
    assign sh    = in_data[2:0];
    assign rol_w = {a_q, a_q} << sh;
    assign ror_w = {a_q, a_q} >> sh;
    assign mul_w = {8'h00, a_q} * {8'h00, in_data};

    always_comb begin
        f = 8'h00;
        unique case (in_op)
            4'h0: f = a_q + in_data;
            4'h1: f = a_q - in_data;
            4'h2: f = a_q & in_data;
            4'h3: f = a_q | in_data;
            4'h4: f = a_q ^ in_data;
            4'h5: f = ~a_q;
            4'h6: f = a_q << sh;
            4'h7: f = a_q >> sh;
            4'h8: f = $signed(a_q) >>> sh;
            4'h9: f = rol_w[15:8];
            4'ha: f = ror_w[7:0];
            4'hb: f = (a_q == in_data) ? 8'h01 : 8'h00;
            4'hc: f = (a_q < in_data) ? 8'h01 : 8'h00;
            4'hd: f = mul_w[7:0];
            4'he: f = a_q;
            4'hf: f = in_data;
            default: f = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            a_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {in_op, f};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else if (clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            if (push) begin
                wr_q  <= wr_q + 1'b1;
                res_q <= res_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_alu_stream_engine.sv
// Bench for alu_stream_engine: queue-based reference model,
// per-cycle compare, directed scenarios and random traffic.
module tb_alu_stream_engine;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic [3:0]       in_op = 4'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic [3:0]       out_op;
    logic [CNT_W-1:0] res_cnt;

    int total = 0;
    int bad = 0;

    alu_stream_engine #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_op(out_op),
        .res_cnt(res_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [3:0] op);
        int sh;
        int p;
        logic [7:0] r;
        sh = int'(b % 8);
        r = a;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: for (int i = 0; i < sh; i++) r = {r[6:0], 1'b0};
            4'h7: for (int i = 0; i < sh; i++) r = {1'b0, r[7:1]};
            4'h8: for (int i = 0; i < sh; i++) r = {r[7], r[7:1]};
            4'h9: for (int i = 0; i < sh; i++) r = {r[6:0], r[7]};
            4'ha: for (int i = 0; i < sh; i++) r = {r[0], r[7:1]};
            4'hb: r = (a == b) ? 8'h01 : 8'h00;
            4'hc: r = (a < b) ? 8'h01 : 8'h00;
            4'hd: begin
                p = int'(a) * int'(b);
                r = p[7:0];
            end
            4'he: r = a;
            default: r = b;
        endcase
        return r;
    endfunction

    // Reference model: result queue, pending-A flag, push counter.
    logic [11:0]      q[$];
    bit               st_b;
    logic [7:0]       ma;
    logic [CNT_W-1:0] mcnt;
    int               sz;
    bit               mhs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            st_b = 1'b0;
            ma = 8'h00;
            mcnt = '0;
        end else if (clr) begin
            q.delete();
            st_b = 1'b0;
            mcnt = '0;
        end else begin
            sz = q.size();
            mhs = in_valid && (sz < DEPTH);
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (mhs) begin
                if (!st_b) begin
                    ma = in_data;
                    st_b = 1'b1;
                end else begin
                    q.push_back({in_op, ref_alu(ma, in_data, in_op)});
                    mcnt = mcnt + 1'b1;
                    st_b = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready),
            32'(rst_n && !clr && (q.size() < DEPTH)));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(q[0][7:0]));
            chk("out_op", 32'(out_op), 32'(q[0][11:8]));
        end
        chk("res_cnt", 32'(res_cnt), 32'(mcnt));
    end

    task automatic beat(input logic [7:0] d, input logic [3:0] op);
        in_valid = 1'b1;
        in_data = d;
        in_op = op;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("beat_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        chk("ref_add", 32'(ref_alu(8'h3C, 8'h0F, 4'h0)), 32'h4B);
        chk("ref_sub", 32'(ref_alu(8'h00, 8'h01, 4'h1)), 32'hFF);
        chk("ref_sra", 32'(ref_alu(8'h80, 8'h03, 4'h8)), 32'hF0);
        chk("ref_rol", 32'(ref_alu(8'h81, 8'h01, 4'h9)), 32'h03);
        chk("ref_mul", 32'(ref_alu(8'h10, 8'h11, 4'hd)), 32'h10);
        chk("ref_ror", 32'(ref_alu(8'h01, 8'h01, 4'ha)), 32'h80);
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_cnt", 32'(res_cnt), 32'd0);
        #14;
        rst_n = 1'b1;
        cycles(1);

        // ADD with immediate visibility
        out_ready = 1'b1;
        beat(8'h3C, 4'h0);
        beat(8'h0F, 4'h0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_data", 32'(out_data), 32'h4B);
        chk("add_op", 32'(out_op), 32'h0);
        chk("add_cnt", 32'(res_cnt), 32'd1);
        cycles(2);

        // SUB wrap
        beat(8'h00, 4'h1);
        beat(8'h01, 4'h1);
        chk("sub_data", 32'(out_data), 32'hFF);
        cycles(2);

        // Backpressure fills FIFO
        pulse_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(8'(i + 1), 4'h0);
            beat(8'h10, 4'h0);
        end
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data = 8'hA5;
        in_op = 4'h0;
        cycles(3);
        chk("bp_held_ready", 32'(in_ready), 32'd0);
        chk("bp_cnt4", 32'(res_cnt), 32'd4);
        chk("bp_head", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        beat(8'hA5, 4'h0);
        beat(8'h5A, 4'h0);
        cycles(8);
        chk("bp_cnt5", 32'(res_cnt), 32'd5);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Push and pop in the same cycle keeps count
        pulse_clr();
        out_ready = 1'b0;
        beat(8'h01, 4'h0);
        beat(8'h01, 4'h0);
        beat(8'h02, 4'h3);
        beat(8'h04, 4'h3);
        beat(8'h81, 4'h9);
        out_ready = 1'b1;
        beat(8'h01, 4'h9);
        out_ready = 1'b0;
        chk("pp_head", 32'(out_data), 32'h06);
        out_ready = 1'b1;
        cycles(1);
        chk("pp_second", 32'(out_data), 32'h03);
        chk("pp_second_op", 32'(out_op), 32'h9);
        cycles(1);
        chk("pp_empty", 32'(out_valid), 32'd0);

        // clr mid-pair discards A
        pulse_clr();
        out_ready = 1'b0;
        beat(8'h55, 4'h0);
        pulse_clr();
        beat(8'h02, 4'h0);
        beat(8'h03, 4'h0);
        chk("clr_data", 32'(out_data), 32'h05);
        chk("clr_cnt", 32'(res_cnt), 32'd1);

        // Async reset mid-cycle with 3 buffered results
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            beat(8'h10, 4'hd);
            beat(8'h11, 4'hd);
        end
        chk("ar_pre_cnt", 32'(res_cnt), 32'd3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd0);
        chk("ar_data", 32'(out_data), 32'd0);
        chk("ar_cnt", 32'(res_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);
        chk("ar_post_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        beat(8'h80, 4'h8);
        beat(8'h03, 4'h8);
        chk("ar_sra", 32'(out_data), 32'hF0);
        chk("ar_post_cnt", 32'(res_cnt), 32'd1);
        cycles(2);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            in_op = 4'($urandom);
            if (i < 400) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 47) == 0);
        end
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
